// File: rtl/ili_pkg.sv
// Shared constants for the ILI9341 frame path: pixel format, colours,
// display geometry and the upscaler state encoding.
package ili_pkg;

  localparam int PIXEL_SIZE = 16;

  localparam logic [15:0] COLOR_FILL   = 16'h001F;
  localparam logic [15:0] COLOR_BLACK  = 16'h0000;
  localparam logic [15:0] COLOR_RED    = 16'hF800;
  localparam logic [15:0] COLOR_PURPLE = 16'h780F;

  localparam int DISP_W = 240;
  localparam int DISP_H = 240;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_CAPT = 3'd2;
  localparam logic [2:0] ST_EMIT = 3'd3;
  localparam logic [2:0] ST_FILL = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    ADDR = ST_ADDR,
    CAPT = ST_CAPT,
    EMIT = ST_EMIT,
    FILL = ST_FILL,
    DONE = ST_DONE
  } upscale_state_e;

endpackage

// File: rtl/upscale_addr_gen.sv
// Nested raster walk (rep_x inside src_x inside rep_y inside src_y) and the
// matching ROM address, tracked incrementally from the start of the source row.
module upscale_addr_gen #(
  parameter int SRC_W  = 80,
  parameter int SRC_H  = 80,
  parameter int SCALE  = 3,
  parameter int ADDR_W = 15
) (
  input  logic              clk_out,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic              hold_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic              rep_last_o,
  output logic              src_x_last_o,
  output logic              row_last_o,
  output logic              frame_last_o,
  output logic [ADDR_W-1:0] rom_addr_o
);

  localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam int RW = (SCALE > 1) ? $clog2(SCALE) : 1;

  logic [XW-1:0]     src_x_q, src_x_d;
  logic [YW-1:0]     src_y_q, src_y_d;
  logic [RW-1:0]     rep_x_q, rep_x_d;
  logic [RW-1:0]     rep_y_q, rep_y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rep_y_last;
  logic              src_y_last;

  assign rep_last_o   = (rep_x_q == RW'(SCALE - 1));
  assign src_x_last_o = (src_x_q == XW'(SRC_W - 1));
  assign rep_y_last   = (rep_y_q == RW'(SCALE - 1));
  assign src_y_last   = (src_y_q == YW'(SRC_H - 1));
  assign row_last_o   = src_x_last_o && rep_y_last;
  assign frame_last_o = rep_last_o && row_last_o && src_y_last;
  assign rom_addr_o   = addr_q;

  // hold_i freezes the address (fill frames) while the counters keep walking.
  always_comb begin
    src_x_d    = src_x_q;
    src_y_d    = src_y_q;
    rep_x_d    = rep_x_q;
    rep_y_d    = rep_y_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    if (clear_i) begin
      src_x_d = '0;
      src_y_d = '0;
      rep_x_d = '0;
      rep_y_d = '0;
      if (!hold_i) begin
        row_base_d = base_i;
        addr_d     = base_i;
      end
    end else if (step_i) begin
      if (!rep_last_o) begin
        rep_x_d = rep_x_q + 1'b1;
      end else begin
        rep_x_d = '0;
        if (!src_x_last_o) begin
          src_x_d = src_x_q + 1'b1;
          if (!hold_i) addr_d = addr_q + 1'b1;
        end else if (!rep_y_last) begin
          src_x_d = '0;
          rep_y_d = rep_y_q + 1'b1;
          if (!hold_i) addr_d = row_base_q;
        end else if (!src_y_last) begin
          src_x_d = '0;
          rep_y_d = '0;
          src_y_d = src_y_q + 1'b1;
          if (!hold_i) begin
            row_base_d = row_base_q + ADDR_W'(SRC_W);
            addr_d     = row_base_q + ADDR_W'(SRC_W);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_out) begin
    if (!rst) begin
      src_x_q    <= '0;
      src_y_q    <= '0;
      rep_x_q    <= '0;
      rep_y_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      src_x_q    <= src_x_d;
      src_y_q    <= src_y_d;
      rep_x_q    <= rep_x_d;
      rep_y_q    <= rep_y_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: rtl/pixel_upscaler.sv
// Reads a low-resolution sprite from a synchronous ROM and emits every source
// pixel SCALE x SCALE times as a raster-ordered valid/ready stream.
module pixel_upscaler
  import ili_pkg::*;
#(
  parameter int                    SRC_W      = 80,
  parameter int                    SRC_H      = 80,
  parameter int                    SCALE      = 3,
  parameter int                    IMAGES     = 5,
  parameter int                    PIXEL_SIZE = ili_pkg::PIXEL_SIZE,
  parameter logic [PIXEL_SIZE-1:0] FILL_COLOR = ili_pkg::COLOR_FILL,
  parameter int                    ADDR_W     = $clog2(SRC_W * SRC_H * IMAGES)
) (
  input  logic                  clk_out,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            img_sel,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [PIXEL_SIZE-1:0] rom_data,
  output logic [PIXEL_SIZE-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  sel_error,
  output logic [2:0]            dbg_state_o,
  output logic [1:0]            dbg_walk_o
);

  // Stream handshake: a beat transfers on a clk_out edge where pix_valid and
  // pix_ready are both high; while pix_valid is high and pix_ready low,
  // pix_valid and pix_data stay unchanged, and pix_valid only falls after a
  // transfer (or on reset).

  upscale_state_e        state_q, state_d;
  logic [PIXEL_SIZE-1:0] pix_data_q, pix_data_d;
  logic                  pix_valid_q, pix_valid_d;
  logic                  sel_err_q, sel_err_d;
  logic                  bad_sel;
  logic [ADDR_W-1:0]     base_d;
  logic                  ag_clear, ag_step, ag_hold;
  logic                  rep_last, src_x_last, row_last, frame_last;

  assign bad_sel = (int'({29'd0, img_sel}) >= IMAGES);
  assign base_d  = ADDR_W'(img_sel) * ADDR_W'(SRC_W * SRC_H);

  upscale_addr_gen #(
    .SRC_W  (SRC_W),
    .SRC_H  (SRC_H),
    .SCALE  (SCALE),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk_out      (clk_out),
    .rst          (rst),
    .clear_i      (ag_clear),
    .step_i       (ag_step),
    .hold_i       (ag_hold),
    .base_i       (base_d),
    .rep_last_o   (rep_last),
    .src_x_last_o (src_x_last),
    .row_last_o   (row_last),
    .frame_last_o (frame_last),
    .rom_addr_o   (rom_addr)
  );

  always_comb begin
    state_d     = state_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    sel_err_d   = sel_err_q;
    ag_clear    = 1'b0;
    ag_step     = 1'b0;
    ag_hold     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ag_clear  = 1'b1;
          sel_err_d = bad_sel;
          if (bad_sel) begin
            ag_hold     = 1'b1;
            pix_data_d  = FILL_COLOR;
            pix_valid_d = 1'b1;
            state_d     = FILL;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: state_d = CAPT;
      CAPT: begin
        pix_data_d  = rom_data;
        pix_valid_d = 1'b1;
        state_d     = EMIT;
      end
      EMIT: begin
        if (pix_ready) begin
          ag_step = 1'b1;
          if (rep_last) begin
            pix_valid_d = 1'b0;
            state_d     = frame_last ? DONE : ADDR;
          end
        end
      end
      // Same walk as EMIT but without ROM traffic or gaps between source pixels.
      FILL: begin
        ag_hold = 1'b1;
        if (pix_ready) begin
          ag_step = 1'b1;
          if (frame_last) begin
            pix_valid_d = 1'b0;
            state_d     = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_out) begin
    if (!rst) begin
      state_q     <= IDLE;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign sel_error   = sel_err_q;
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign frame_done  = (state_q == DONE);
  assign dbg_state_o = state_q;
  assign dbg_walk_o  = {row_last, src_x_last};

endmodule

// File: doc/pixel_upscaler.md
Name: pixel_upscaler

Overview:
- Upstream pixel source for the ILI9341 frame path.
- Reads a low-resolution sprite (default 80x80, RGB565) from a synchronous image ROM holding IMAGES frames back to back.
- Replicates each source pixel SCALE x SCALE times, emitting a raster-ordered 240x240 stream over a valid/ready handshake.
- Consumed by the top-level pixel counter that feeds the SPI display controller.

Parameters:
- SRC_W, 80, source image width in pixels.
- SRC_H, 80, source image height in pixels.
- SCALE, 3, integer replication factor per axis (>=1).
- IMAGES, 5, number of images stored consecutively in ROM.
- PIXEL_SIZE, 16, pixel width (RGB565).
- FILL_COLOR, 16'h001F, colour emitted for an invalid image select.
- ADDR_W, $clog2(SRC_W*SRC_H*IMAGES), ROM address width.

Ports:
- clk_out  in  1  pixel-domain clock.
- rst  in  1  reset: synchronous, active-low.
- start  in  1  one-cycle request to emit a full frame; sampled only in IDLE.
- img_sel  in  3  image index; latched on an accepted start.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  PIXEL_SIZE  ROM read data; valid one cycle after rom_addr is registered.
- pix_data  out  PIXEL_SIZE  output pixel.
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  consumer accepts a beat when pix_valid && pix_ready.
- busy  out  1  frame in progress (not IDLE).
- frame_done  out  1  one-cycle pulse after the last beat is accepted.
- sel_error  out  1  latched img_sel was >= IMAGES; held until the next start.

Behaviour:
- Reset (rst=0 at a clk_out edge): state=IDLE. pix_valid=0, pix_data=0, rom_addr=0, busy=0, frame_done=0, sel_error=0. All counters are cleared. A frame in progress is discarded.
- Counters:
  - src_x 0..SRC_W-1 and src_y 0..SRC_H-1.
  - rep_x 0..SCALE-1 (horizontal repeat) and rep_y 0..SCALE-1 (row repeat).
  - base = sel*SRC_W*SRC_H, computed at start in ADDR_W-bit arithmetic.
- Address: rom_addr = base + src_y*SRC_W + src_x. Registered; no combinational path from inputs.
- FSM:
  - IDLE: on start=1, latch sel=img_sel, busy=1, clear counters. Go to ADDR, or to FILL if img_sel>=IMAGES (also set sel_error=1).
  - ADDR: rom_addr is presented -> CAPT.
  - CAPT: pix_data<=rom_data, pix_valid<=1 -> EMIT.
  - EMIT: on each handshake, increment rep_x. When rep_x wraps (SCALE beats accepted):
    - If src_x != SRC_W-1: src_x++ -> ADDR.
    - Else if rep_y != SCALE-1: src_x=0, rep_y++ -> ADDR (the row is re-read).
    - Else if src_y != SRC_H-1: src_x=0, rep_y=0, src_y++ -> ADDR.
    - Else -> DONE.
    - pix_valid drops in the cycle after the wrapping handshake.
  - FILL: pix_data=FILL_COLOR, pix_valid=1 for SRC_W*SRC_H*SCALE*SCALE beats. The same counter walk is used but no ROM reads occur; rom_addr holds. -> DONE.
  - DONE: frame_done=1 for exactly one cycle, pix_valid=0, busy=0 -> IDLE.
- Handshake rules:
  - While pix_valid=1 && pix_ready=0, pix_data and pix_valid must be held stable.
  - pix_valid never drops without a handshake, except on reset.
- Latency: start -> first pix_valid = 3 cycles (IDLE->ADDR->CAPT->EMIT). Each source pixel costs 2 non-emitting cycles plus SCALE beats.
- Frame size: exactly (SRC_W*SCALE)*(SRC_H*SCALE) beats (57600 at defaults).
- Ignored inputs: start while busy is ignored. img_sel changes after the start cycle have no effect.
- Simultaneous events: rst=0 dominates start and pix_ready. start in the DONE cycle is ignored; it must arrive in IDLE.
- SCALE=1 is a pass-through; the wrap logic must still be correct.

Decomposition:
- Shared package ili_pkg:
  - PIXEL_SIZE, RGB565 colour constants (FILL_COLOR, black, red, purple).
  - Display dims 240x240.
  - State encoding localparams for IDLE/ADDR/CAPT/EMIT/FILL/DONE.
- One sub-module: upscale_addr_gen, holding the four nested wrap counters and the base/address computation.
  - Inputs: step, clear.
  - Outputs: src_x_last, row_last, frame_last, rom_addr.

Test Plan (bench overrides SRC_W=4, SRC_H=2, SCALE=3, IMAGES=5; ROM word = address):
- Continuous ready: img_sel=0, start, pix_ready=1.
  - 72 beats.
  - Rows 0-2 = 0,0,0,1,1,1,2,2,2,3,3,3; rows 3-5 = 4,4,4,...,7,7,7.
  - First valid 3 cycles after start.
  - frame_done pulses once, 1 cycle after beat 72.
- Image base: img_sel=2 -> first rom_addr=16, first pixel 16, last pixel 23, 72 beats.
- Backpressure: pix_ready random at 50%.
  - Beat sequence is identical to the continuous-ready case.
  - pix_data is stable on every stalled cycle.
  - No beat is dropped or duplicated.
- Bad select: img_sel=7 -> sel_error=1, 72 beats of 16'h001F, rom_addr constant, frame_done pulses.
- Ignored inputs: start re-asserted and img_sel changed to 3 at beat 10 -> frame continues from image 0 unchanged; no second frame.
- Mid-frame reset: rst=0 at beat 30.
  - Next cycle: pix_valid=0, busy=0, rom_addr=0, no frame_done.
  - A following start with img_sel=1 begins at rom_addr=8.
